// File: rtl/vga_stage_rect_multi.sv
// Rectangle overlay pixel stage: up to 2**MULTIBITS rectangles with per-rectangle compositing,
// double-buffered config committed on frame start, 2-deep stallable pipeline.
module vga_stage_rect_multi #(
  parameter int unsigned WIDTHBITS  = 10,
  parameter int unsigned HEIGHTBITS = 10,
  parameter int unsigned COLORBITS  = 8,
  parameter int unsigned MULTIBITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [COLORBITS-1:0]  st__color_0a,
  input  logic [WIDTHBITS-1:0]  st__x_0a,
  input  logic [HEIGHTBITS-1:0] st__y_0a,
  input  logic [MULTIBITS-1:0]  st__conf_multi_index,
  input  logic                  st__a0,
  input  logic [31:0]           st__data,
  input  logic                  vg__rect_write,
  input  logic                  vg__frame_start,
  input  logic                  vg__stall,
  output logic [COLORBITS-1:0]  st__color_2a,
  output logic [WIDTHBITS-1:0]  st__x_2a,
  output logic [HEIGHTBITS-1:0] st__y_2a,
  output logic                  st__hit_2a,
  output logic                  st__pending
);

  localparam int unsigned W = WIDTHBITS;
  localparam int unsigned H = HEIGHTBITS;
  localparam int unsigned C = COLORBITS;
  localparam int unsigned N = 2 ** MULTIBITS;

  localparam logic [1:0] MODE_OR      = 2'b00;
  localparam logic [1:0] MODE_REPLACE = 2'b01;
  localparam logic [1:0] MODE_XOR     = 2'b10;
  localparam logic [1:0] MODE_AND     = 2'b11;

  if (WIDTHBITS + HEIGHTBITS + COLORBITS + 1 > 32) begin : g_width_check
    $error("vga_stage_rect_multi: R0 fields do not fit in 32 bits");
  end

  // Shadow (CPU-visible) and active (pixel-visible) banks
  logic [W-1:0] sh_x1 [N], sh_x2 [N], act_x1 [N], act_x2 [N], nx_x1 [N], nx_x2 [N];
  logic [H-1:0] sh_y1 [N], sh_y2 [N], act_y1 [N], act_y2 [N], nx_y1 [N], nx_y2 [N];
  logic [C-1:0] sh_color [N], act_color [N], nx_color [N];
  logic [1:0]   sh_mode [N], act_mode [N], nx_mode [N];
  logic [N-1:0] sh_en, act_en, nx_en;

  logic [N-1:0] hit_c;
  logic [N-1:0] hit_1a;
  logic [C-1:0] color_1a;
  logic [W-1:0] x_1a;
  logic [H-1:0] y_1a;
  logic [C-1:0] acc_c;
  logic         unused_data_c;

  // Spare data bits differ between R0 and R1; fold them into a sink.
  assign unused_data_c = ^st__data;

  // Post-write shadow values; commit copies these so a same-cycle write is included
  always_comb begin
    nx_x1    = sh_x1;
    nx_y1    = sh_y1;
    nx_x2    = sh_x2;
    nx_y2    = sh_y2;
    nx_color = sh_color;
    nx_mode  = sh_mode;
    nx_en    = sh_en;
    if (vg__rect_write) begin
      if (!st__a0) begin
        nx_x1[st__conf_multi_index]    = st__data[W-1:0];
        nx_y1[st__conf_multi_index]    = st__data[W+H-1:W];
        nx_color[st__conf_multi_index] = st__data[W+H+C-1:W+H];
        nx_en[st__conf_multi_index]    = st__data[W+H+C];
      end else begin
        nx_x2[st__conf_multi_index]   = st__data[W-1:0];
        nx_y2[st__conf_multi_index]   = st__data[W+H-1:W];
        nx_mode[st__conf_multi_index] = st__data[W+H+1:W+H];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < int'(N); i++) begin
        sh_x1[i]     <= '0;
        sh_y1[i]     <= '0;
        sh_x2[i]     <= '0;
        sh_y2[i]     <= '0;
        sh_color[i]  <= '0;
        sh_mode[i]   <= '0;
        act_x1[i]    <= '0;
        act_y1[i]    <= '0;
        act_x2[i]    <= '0;
        act_y2[i]    <= '0;
        act_color[i] <= '0;
        act_mode[i]  <= '0;
      end
      sh_en       <= '0;
      act_en      <= '0;
      st__pending <= 1'b0;
    end else begin
      sh_x1    <= nx_x1;
      sh_y1    <= nx_y1;
      sh_x2    <= nx_x2;
      sh_y2    <= nx_y2;
      sh_color <= nx_color;
      sh_mode  <= nx_mode;
      sh_en    <= nx_en;
      if (vg__frame_start) begin
        act_x1      <= nx_x1;
        act_y1      <= nx_y1;
        act_x2      <= nx_x2;
        act_y2      <= nx_y2;
        act_color   <= nx_color;
        act_mode    <= nx_mode;
        act_en      <= nx_en;
        st__pending <= 1'b0;
      end else if (vg__rect_write) begin
        st__pending <= 1'b1;
      end
    end
  end

  // Inclusive-bounds hit test; inverted bounds can never satisfy both compares
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      hit_c[i] = act_en[i] &&
                 (st__x_0a >= act_x1[i]) && (st__x_0a <= act_x2[i]) &&
                 (st__y_0a >= act_y1[i]) && (st__y_0a <= act_y2[i]);
    end
  end

  // In-order fold so the highest-index hit is applied last
  always_comb begin
    acc_c = color_1a;
    for (int i = 0; i < int'(N); i++) begin
      if (hit_1a[i]) begin
        case (act_mode[i])
          MODE_OR:      acc_c = acc_c | act_color[i];
          MODE_REPLACE: acc_c = act_color[i];
          MODE_XOR:     acc_c = acc_c ^ act_color[i];
          MODE_AND:     acc_c = acc_c & act_color[i];
          default:      acc_c = acc_c;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_1a       <= '0;
      color_1a     <= '0;
      x_1a         <= '0;
      y_1a         <= '0;
      st__color_2a <= '0;
      st__x_2a     <= '0;
      st__y_2a     <= '0;
      st__hit_2a   <= 1'b0;
    end else if (!vg__stall) begin
      hit_1a       <= hit_c;
      color_1a     <= st__color_0a;
      x_1a         <= st__x_0a;
      y_1a         <= st__y_0a;
      st__color_2a <= acc_c;
      st__x_2a     <= x_1a;
      st__y_2a     <= y_1a;
      st__hit_2a   <= |hit_1a;
    end
  end

endmodule
